mmio_byte_fifo: RTL and testbench
=================================

# mmio_byte_fifo

Memory-mapped responder on the CPU's MEM-stage data bus (rd/wr/addr/wdata/rdata, same bus as DataMem, Peripheral and UART). It provides a TX byte FIFO that the CPU fills and an external stream consumer drains, and an RX byte FIFO that an external stream producer fills and the CPU drains. It also has status and control registers and a level-sensitive interrupt, and sits in the address window above the UART. Its rdata joins the top-level ReadData mux as one more source.

## Interface
- BASE, 32'h40000020, window base; 16-byte window; BASE[3:0] must be 0
- DEPTH, 8, entries per FIFO; power of two, ≥2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rd  in  1  bus read strobe (EX_MEM MemRd)
- wr  in  1  bus write strobe (EX_MEM MemWr)
- addr  in  32  bus byte address (EX_MEM ALUOut)
- wdata  in  32  bus write data
- rdata  out  32  bus read data, combinational
- irqout  out  1  interrupt request, level
- tx_valid  out  1  TX head byte available
- tx_data  out  8  TX head byte
- tx_ready  in  1  consumer accepts TX byte
- rx_valid  in  1  producer offers RX byte
- rx_data  in  8  RX byte
- rx_ready  out  1  RX FIFO can accept

## Operation
- Hit when addr[31:4]==BASE[31:4]. Register select is addr[3:2]; addr[1:0] is ignored.
- Offset 0x0 TXDATA:
  - Write pushes wdata[7:0] when TX is not full.
  - When TX is full, the write is dropped and tx_ovf is set.
  - Reads return 0.
- Offset 0x4 RXDATA:
  - Read returns {24'b0, RX head} and pops at the clock edge when RX is non-empty.
  - When RX is empty, a read returns 0 and causes no pop and no flag change.
  - Writes are ignored.
- Offset 0x8 STATUS:
  - Read returns {26'b0, rx_ovf, tx_ovf, rx_full, rx_empty, tx_full, tx_empty}.
  - Writes are W1C on bits 5 (rx_ovf) and 4 (tx_ovf); other bits are ignored.
- Offset 0xC CTRL:
  - R/W bits [1:0]: bit0 rx_irq_en, bit1 tx_irq_en.
  - Reads return {30'b0, ctrl}.
- rdata is 0 when rd=0 or there is no hit.
- Writes outside the window, or with wr=0, have no effect.
- TX stream:
  - tx_valid = ~tx_empty; tx_data = TX head.
  - Pop on tx_valid & tx_ready.
- RX stream:
  - rx_ready = ~rx_full.
  - Push rx_data on rx_valid & rx_ready.
  - rx_ovf is set when rx_valid=1 while full; the byte is lost.
- irqout = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty).
- FIFO behaviour:
  - Circular, with rd/wr pointers of log2(DEPTH) bits and wrapping naturally.
  - Occupancy counter is log2(DEPTH)+1 bits.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves occupancy unchanged.
- Full and empty decisions use pre-edge state:
  - A CPU write to a full TX is dropped even if the consumer pops in the same cycle.
  - A producer push to a full RX is refused even if the CPU pops in the same cycle.
- Overflow set and W1C clear in the same cycle: set wins.

## Timing
- Reset (async assert, reset=0):
  - FIFOs empty, pointers 0.
  - tx_ovf=0, rx_ovf=0, ctrl=0.
  - Outputs: tx_valid=0, tx_data=0, rx_ready=1, irqout=0, rdata=0.
- All state updates occur at posedge clk. Reset asserted mid-transfer discards FIFO contents immediately.
- Read latency is 0: rdata is valid in the same cycle as rd/addr, so the MEM_WB register captures it at the next edge. The RXDATA pop takes effect at that same edge.
- Write latency: a pushed byte appears on tx_valid/tx_data one cycle after the wr edge.
- RX latency: a byte pushed at edge N is readable at RXDATA in cycle N+1.
- Flags and irqout update one cycle after the causing edge. irqout is combinational from registered state only and has no bus-input path.

## Structure
- Shared package contents:
  - Register offsets: TXDATA=2'd0, RXDATA=2'd1, STATUS=2'd2, CTRL=2'd3.
  - STATUS bit indices.
  - CTRL bit indices.
  - Default BASE.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Ports: push, pop, din, dout, empty, full.
  - Instantiated twice: TX and RX.
  - Internal guard: push while full and pop while empty are ignored.
- Top of block: address decode, read mux, flag/ctrl registers, interrupt logic.

## Test plan
- TX fill: reset, 9 writes of 0x11..0x19 to BASE+0 with tx_ready=0 → STATUS=0x16 (tx_ovf, tx_full, rx_empty); tx_data=0x11. Then tx_ready=1 for 8 cycles → bytes 0x11..0x18 in order, then tx_valid=0.
- RX path: producer pushes 0xA5, 0x5A → RXDATA reads give 0xA5 then 0x5A. A third read gives 0 with no pop and no flag.
- RX overflow plus W1C: push 9 bytes with DEPTH=8 → rx_ready=0 after 8 pushes, STATUS bit5=1. Write 0x20 to STATUS → bit5=0 and data is intact.
- Wrap and simultaneous traffic: stream 20 bytes through TX with concurrent CPU writes and tx_ready=1 → output order is preserved across pointer wrap, and occupancy never exceeds 8.
- IRQ: CTRL=0x1 with RX empty → irqout=0. One RX push → irqout=1; RXDATA read → irqout=0. CTRL=0x2 → irqout=1 while TX is empty.
- Decode and reset: a write to 0x40000030 or 0x40000018 changes nothing, and rd at 0x40000030 → rdata=0. Async reset asserted mid-stream → tx_valid=0 and rx_ready=1 immediately, before any clock edge.

Source files
------------

// File: rtl/mmio_byte_fifo_pkg.sv
// Shared definitions for the memory-mapped byte FIFO responder:
// register map, STATUS/CTRL bit positions and the default window base.
package mmio_byte_fifo_pkg;

  localparam int unsigned BUS_W    = 32;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned STATUS_W = 6;
  localparam int unsigned CTRL_W   = 2;

  localparam logic [BUS_W-1:0] DEFAULT_BASE = 32'h4000_0020;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_RXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } reg_sel_e;

  localparam int unsigned ST_TX_EMPTY = 0;
  localparam int unsigned ST_TX_FULL  = 1;
  localparam int unsigned ST_RX_EMPTY = 2;
  localparam int unsigned ST_RX_FULL  = 3;
  localparam int unsigned ST_TX_OVF   = 4;
  localparam int unsigned ST_RX_OVF   = 5;

  localparam int unsigned CTRL_RX_IRQ_EN = 0;
  localparam int unsigned CTRL_TX_IRQ_EN = 1;

endpackage

// File: rtl/mmio_byte_fifo_sync_fifo.sv
// Circular synchronous FIFO; push-when-full and pop-when-empty are ignored.
// dout reads as zero while empty so the head never exposes stale storage.
module mmio_byte_fifo_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observable through dout when non-empty.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_byte_fifo.sv
// MEM-stage bus responder with a CPU-to-stream TX FIFO, a stream-to-CPU RX FIFO,
// sticky overflow flags, interrupt enables and a level interrupt.
module mmio_byte_fifo
  import mmio_byte_fifo_pkg::*;
#(
  parameter logic [31:0] BASE  = DEFAULT_BASE,
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready
);

  logic              hit;
  reg_sel_e          sel;
  logic              wr_tx, wr_status, wr_ctrl, rd_rx;
  logic              tx_empty, tx_full, rx_empty, rx_full;
  logic [BYTE_W-1:0] rx_head;
  logic              tx_ovf_q, tx_ovf_d;
  logic              rx_ovf_q, rx_ovf_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [STATUS_W-1:0] status_c;
  logic              unused_bus_bits;

  assign unused_bus_bits = ^{addr[1:0], wdata[BUS_W-1:BYTE_W]};

  assign hit       = (addr[31:4] == BASE[31:4]);
  assign sel       = reg_sel_e'(addr[3:2]);
  assign wr_tx     = wr & hit & (sel == REG_TXDATA);
  assign wr_status = wr & hit & (sel == REG_STATUS);
  assign wr_ctrl   = wr & hit & (sel == REG_CTRL);
  assign rd_rx     = rd & hit & (sel == REG_RXDATA);

  mmio_byte_fifo_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr_tx),
    .pop   (tx_ready),
    .din   (wdata[BYTE_W-1:0]),
    .dout  (tx_data),
    .empty (tx_empty),
    .full  (tx_full)
  );

  mmio_byte_fifo_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (rx_valid),
    .pop   (rd_rx),
    .din   (rx_data),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  always_comb begin
    status_c              = '0;
    status_c[ST_TX_EMPTY] = tx_empty;
    status_c[ST_TX_FULL]  = tx_full;
    status_c[ST_RX_EMPTY] = rx_empty;
    status_c[ST_RX_FULL]  = rx_full;
    status_c[ST_TX_OVF]   = tx_ovf_q;
    status_c[ST_RX_OVF]   = rx_ovf_q;
  end

  // Overflow set takes priority over a same-cycle W1C clear.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    ctrl_d   = ctrl_q;
    if (wr_status && wdata[ST_TX_OVF]) tx_ovf_d = 1'b0;
    if (wr_status && wdata[ST_RX_OVF]) rx_ovf_d = 1'b0;
    if (wr_tx && tx_full)              tx_ovf_d = 1'b1;
    if (rx_valid && rx_full)           rx_ovf_d = 1'b1;
    if (wr_ctrl)                       ctrl_d   = wdata[CTRL_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      ctrl_q   <= ctrl_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      case (sel)
        REG_RXDATA: rdata = BUS_W'(rx_head);
        REG_STATUS: rdata = BUS_W'(status_c);
        REG_CTRL:   rdata = BUS_W'(ctrl_q);
        default:    rdata = '0;
      endcase
    end
  end

  assign irqout = (ctrl_q[CTRL_RX_IRQ_EN] & ~rx_empty) |
                  (ctrl_q[CTRL_TX_IRQ_EN] & tx_empty);

endmodule

// File: tb/tb_mmio_byte_fifo.sv
// Scoreboard bench for mmio_byte_fifo: directed stimulus queues expected read data and
// TX stream bytes; a negedge monitor compares them as the DUT presents them.
module tb_mmio_byte_fifo;

  localparam logic [31:0] BASE = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        irqout, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0]  tx_data, rx_data;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];

  mmio_byte_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .irqout   (irqout),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every bus read and every TX handshake must match the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      if (rd) begin
        if (rd_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL rdata: unexpected read got 0x%0h", rdata);
        end else begin
          check("rdata", rdata, rd_q.pop_front());
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL tx_data: unexpected byte got 0x%0h", tx_data);
        end else begin
          check("tx_data", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp);
    addr = a; rd = 1'b1;
    rd_q.push_back(exp);
    tick();
    rd = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #1;
    check("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("reset_tx_data",  {24'b0, tx_data},  32'd0);
    check("reset_rx_ready", {31'b0, rx_ready}, 32'd1);
    check("reset_irqout",   {31'b0, irqout},   32'd0);
    check("reset_rdata",    rdata,             32'd0);
    #12 reset = 1'b1;
    tick();
    bus_read(BASE + 32'h8, 32'h05);

    // TX fill: ninth write overflows and is dropped.
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_q.push_back(8'(8'h11 + i));
      bus_write(BASE, 32'(8'h11 + i));
    end
    check("fill_tx_data",  {24'b0, tx_data},  32'h11);
    check("fill_tx_valid", {31'b0, tx_valid}, 32'd1);
    bus_read(BASE + 32'h8, 32'h16);
    bus_read(BASE, 32'h0);
    tx_ready = 1'b1;
    repeat (8) tick();
    check("drain_tx_valid", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    bus_write(BASE + 32'h8, 32'h10);
    bus_read(BASE + 32'h8, 32'h05);

    // RX path and empty read.
    rx_push(8'hA5);
    rx_push(8'h5A);
    bus_read(BASE + 32'h4, 32'hA5);
    bus_read(BASE + 32'h4, 32'h5A);
    bus_read(BASE + 32'h4, 32'h0);
    bus_read(BASE + 32'h8, 32'h05);

    // RX overflow, then W1C of rx_ovf with data kept.
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'(8'h30 + i);
      if (i == 8) check("rx_ready_full", {31'b0, rx_ready}, 32'd0);
      tick();
    end
    rx_valid = 1'b0;
    bus_read(BASE + 32'h8, 32'h29);
    bus_write(BASE + 32'h8, 32'h20);
    bus_read(BASE + 32'h8, 32'h09);
    for (int i = 0; i < 8; i++) bus_read(BASE + 32'h4, 32'(8'h30 + i));
    bus_read(BASE + 32'h8, 32'h05);

    // Streaming with wrap and a consumer stall that stays under DEPTH.
    for (int i = 0; i < 20; i++) begin
      tx_ready = !(i >= 5 && i < 11);
      tx_q.push_back(8'(8'h40 + i));
      bus_write(BASE, 32'(8'h40 + i));
    end
    tx_ready = 1'b1;
    for (int k = 0; k < 40 && tx_q.size() != 0; k++) tick();
    check("stream_drained", tx_q.size(), 32'd0);
    check("stream_tx_valid", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    bus_read(BASE + 32'h8, 32'h05);

    // Interrupt enables.
    bus_write(BASE + 32'hC, 32'h1);
    check("irq_rx_empty", {31'b0, irqout}, 32'd0);
    rx_push(8'h77);
    check("irq_rx_data", {31'b0, irqout}, 32'd1);
    bus_read(BASE + 32'h4, 32'h77);
    check("irq_rx_popped", {31'b0, irqout}, 32'd0);
    bus_write(BASE + 32'hC, 32'h2);
    check("irq_tx_empty", {31'b0, irqout}, 32'd1);
    bus_read(BASE + 32'hC, 32'h2);
    bus_write(BASE + 32'hC, 32'h0);
    check("irq_off", {31'b0, irqout}, 32'd0);

    // Decode: writes just outside the window have no effect.
    bus_write(32'h4000_0030, 32'h99);
    bus_write(32'h4000_0018, 32'h99);
    check("decode_tx_valid", {31'b0, tx_valid}, 32'd0);
    bus_read(32'h4000_0030, 32'h0);
    bus_read(BASE + 32'h8, 32'h05);
    bus_read(BASE + 32'hC, 32'h0);

    // Asynchronous reset while both FIFOs hold data.
    for (int i = 0; i < 3; i++) bus_write(BASE, 32'(8'hC0 + i));
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'(8'hD0 + i);
      tick();
    end
    rx_valid = 1'b0;
    check("pre_rst_tx_valid", {31'b0, tx_valid}, 32'd1);
    check("pre_rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("async_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("async_rx_ready", {31'b0, rx_ready}, 32'd1);
    check("async_tx_data",  {24'b0, tx_data},  32'd0);
    #3 reset = 1'b1;
    tick();
    bus_read(BASE + 32'h8, 32'h05);
    bus_read(BASE + 32'h4, 32'h0);
    tick();

    check("rd_queue_empty", rd_q.size(), 32'd0);
    check("tx_queue_empty", tx_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
